// File: rtl/square_seq.sv
// Sequencer that streams element pairs from a dual-read register file through the
// external two-lane Square unit and writes both results back. Optional abort via SQUARE_SEQ_ABORT_EN.
module square_seq #(
    parameter int WIDTH = 24,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [AW:0]      len_i,
    input  logic [AW-1:0]    src_base_i,
    input  logic [AW-1:0]    dst_base_i,
`ifdef SQUARE_SEQ_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [AW-1:0]    rd_addr_1_o,
    output logic [AW-1:0]    rd_addr_2_o,
    input  logic [WIDTH-1:0] rd_data_1_i,
    input  logic [WIDTH-1:0] rd_data_2_i,
    output logic [WIDTH-1:0] sq_data_1_o,
    output logic [WIDTH-1:0] sq_data_2_o,
    input  logic [WIDTH-1:0] sq_res_1_i,
    input  logic [WIDTH-1:0] sq_res_2_i,
    output logic             wr_en_1_o,
    output logic             wr_en_2_o,
    output logic [AW-1:0]    wr_addr_1_o,
    output logic [AW-1:0]    wr_addr_2_o,
    output logic [WIDTH-1:0] wr_data_1_o,
    output logic [WIDTH-1:0] wr_data_2_o
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_FEED, S_WRITE, S_DONE} state_t;

    localparam logic [AW-1:0] A_ONE = 1;
    localparam logic [AW:0]   L_TWO = 2;
    localparam logic [AW-2:0] K_ONE = 1;

    state_t           state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [AW-2:0]    k_q, k_d;
    logic [WIDTH-1:0] sq1_q, sq1_d;
    logic [WIDTH-1:0] sq2_q, sq2_d;
    logic             ab_q, ab_d;

    // 2k and 2k+1 never exceed 2^AW-1, so these fit exactly without carries.
    logic [AW-1:0] pair_off;
    logic [AW:0]   idx2;
    logic [AW:0]   pair_end;
    logic          lane2_live;
    logic          last_pair;

    assign pair_off   = {k_q, 1'b0};
    assign idx2       = {1'b0, k_q, 1'b1};
    assign pair_end   = {1'b0, k_q, 1'b0} + L_TWO;
    assign lane2_live = idx2 < len_q;
    assign last_pair  = pair_end >= len_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            k_q     <= '0;
            sq1_q   <= '0;
            sq2_q   <= '0;
            ab_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            k_q     <= k_d;
            sq1_q   <= sq1_d;
            sq2_q   <= sq2_d;
            ab_q    <= ab_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        src_d       = src_q;
        dst_d       = dst_q;
        k_d         = k_q;
        sq1_d       = sq1_q;
        sq2_d       = sq2_q;
        ab_d        = ab_q;
        rd_en_o     = 1'b0;
        rd_addr_1_o = '0;
        rd_addr_2_o = '0;
        wr_en_1_o   = 1'b0;
        wr_en_2_o   = 1'b0;
        wr_addr_1_o = '0;
        wr_addr_2_o = '0;
        done_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    k_d     = '0;
                    ab_d    = 1'b0;
                    state_d = (len_i == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                rd_en_o     = 1'b1;
                rd_addr_1_o = src_q + pair_off;
                rd_addr_2_o = src_q + pair_off + A_ONE;
                state_d     = S_FEED;
`ifdef SQUARE_SEQ_ABORT_EN
                if (abort_i) begin
                    ab_d    = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_FEED: begin
                // Odd-length tail: lane 2 has no element, feed a zero.
                sq1_d   = rd_data_1_i;
                sq2_d   = lane2_live ? rd_data_2_i : '0;
                state_d = S_WRITE;
`ifdef SQUARE_SEQ_ABORT_EN
                if (abort_i) begin
                    ab_d    = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_WRITE: begin
                wr_en_1_o   = 1'b1;
                wr_en_2_o   = lane2_live;
                wr_addr_1_o = dst_q + pair_off;
                wr_addr_2_o = dst_q + pair_off + A_ONE;
                if (last_pair) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + K_ONE;
                    state_d = S_READ;
                end
`ifdef SQUARE_SEQ_ABORT_EN
                if (abort_i) begin
                    ab_d    = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o      = (state_q != S_IDLE);
    assign sq_data_1_o = sq1_q;
    assign sq_data_2_o = sq2_q;
    assign wr_data_1_o = sq_res_1_i;
    assign wr_data_2_o = sq_res_2_i;

`ifdef SQUARE_SEQ_ABORT_EN
    assign aborted_o = (state_q == S_DONE) && ab_q;
`else
    // Abort flag is only consumed when the abort feature is built in.
    logic unused_ab;
    assign unused_ab = ab_q;
`endif

endmodule

// File: tb/tb_square_seq.sv
// Self-checking bench for square_seq: random register-file contents and run parameters
// checked cycle by cycle against an element-level schedule model.
module tb_square_seq;
    localparam int W  = 24;
    localparam int AW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW:0]   len_i;
    logic [AW-1:0] src_base_i, dst_base_i;
    logic          busy_o, done_o, rd_en_o;
    logic [AW-1:0] rd_addr_1_o, rd_addr_2_o;
    logic [W-1:0]  rd_data_1_i, rd_data_2_i;
    logic [W-1:0]  sq_data_1_o, sq_data_2_o;
    logic [W-1:0]  sq_res_1_i, sq_res_2_i;
    logic          wr_en_1_o, wr_en_2_o;
    logic [AW-1:0] wr_addr_1_o, wr_addr_2_o;
    logic [W-1:0]  wr_data_1_o, wr_data_2_o;
`ifdef SQUARE_SEQ_ABORT_EN
    logic          abort_i;
    logic          aborted_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] rf [2**AW];

    square_seq #(.WIDTH(W), .AW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .src_base_i(src_base_i), .dst_base_i(dst_base_i),
`ifdef SQUARE_SEQ_ABORT_EN
        .abort_i(abort_i), .aborted_o(aborted_o),
`endif
        .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
        .rd_addr_1_o(rd_addr_1_o), .rd_addr_2_o(rd_addr_2_o),
        .rd_data_1_i(rd_data_1_i), .rd_data_2_i(rd_data_2_i),
        .sq_data_1_o(sq_data_1_o), .sq_data_2_o(sq_data_2_o),
        .sq_res_1_i(sq_res_1_i), .sq_res_2_i(sq_res_2_i),
        .wr_en_1_o(wr_en_1_o), .wr_en_2_o(wr_en_2_o),
        .wr_addr_1_o(wr_addr_1_o), .wr_addr_2_o(wr_addr_2_o),
        .wr_data_1_o(wr_data_1_o), .wr_data_2_o(wr_data_2_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] sq(input logic [W-1:0] x);
        logic [2*W-1:0] p;
        p = x * x;
        return p[W-1:0];
    endfunction

    // Square unit stand-in and synchronous register file; junk appears when not read.
    assign sq_res_1_i = sq(sq_data_1_o);
    assign sq_res_2_i = sq(sq_data_2_o);
    always @(posedge clk_i) begin
        if (rd_en_o) begin
            rd_data_1_i <= rf[rd_addr_1_o];
            rd_data_2_i <= rf[rd_addr_2_o];
        end else begin
            rd_data_1_i <= W'($urandom);
            rd_data_2_i <= W'($urandom);
        end
    end

    wire any_out = |{busy_o, done_o, rd_en_o, rd_addr_1_o, rd_addr_2_o, sq_data_1_o, sq_data_2_o,
`ifdef SQUARE_SEQ_ABORT_EN
                     aborted_o,
`endif
                     wr_en_1_o, wr_en_2_o, wr_addr_1_o, wr_addr_2_o, wr_data_1_o, wr_data_2_o};

    task automatic scramble_inputs();
        len_i      = (AW+1)'($urandom_range(0, 2**AW));
        src_base_i = AW'($urandom);
        dst_base_i = AW'($urandom);
    endtask

    // One run of l elements; poke_c names a cycle in which a stray start is pulsed.
    task automatic run_check(input int l, input int s, input int d, input int poke_c);
        int np, dc, p;
        logic exp_rd, exp_w1, exp_w2;
        logic [AW-1:0] ea1, ea2;
        logic [W-1:0] e_sq2;
        np = (l + 1) / 2;
        dc = 1 + 3 * np;
        start_i    = 1'b1;
        len_i      = (AW+1)'(l);
        src_base_i = AW'(s);
        dst_base_i = AW'(d);
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        scramble_inputs();
        for (int c = 1; c <= dc; c++) begin
            p      = (c - 1) / 3;
            exp_rd = (c < dc) && ((c - 1) % 3 == 0);
            exp_w1 = (c < dc) && ((c - 1) % 3 == 2);
            exp_w2 = exp_w1 && (2 * p + 1 < l);
            ea1    = AW'(s + 2 * p);
            ea2    = AW'(s + 2 * p + 1);
            e_sq2  = (2 * p + 1 < l) ? rf[ea2] : '0;
            checks++;
            if ({busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o} !== {1'b1, c == dc, exp_rd, exp_w1, exp_w2}) begin
                errors++;
                $display("FAIL strobes len=%0d cycle=%0d: got busy,done,rd,w1,w2=%b want %b", l, c,
                         {busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o}, {1'b1, c == dc, exp_rd, exp_w1, exp_w2});
            end
            if (exp_rd) begin
                checks++;
                if ({rd_addr_1_o, rd_addr_2_o} !== {ea1, ea2}) begin
                    errors++;
                    $display("FAIL rd_addr len=%0d pair=%0d: got %0d/%0d want %0d/%0d", l, p,
                             rd_addr_1_o, rd_addr_2_o, ea1, ea2);
                end
            end
            if (exp_w1) begin
                checks++;
                if ({wr_addr_1_o, wr_data_1_o, sq_data_1_o, sq_data_2_o} !==
                    {AW'(d + 2 * p), sq(rf[ea1]), rf[ea1], e_sq2}) begin
                    errors++;
                    $display("FAIL lane1 write len=%0d pair=%0d: got a=%0d d=%h sq=%h/%h want a=%0d d=%h sq=%h/%h",
                             l, p, wr_addr_1_o, wr_data_1_o, sq_data_1_o, sq_data_2_o,
                             AW'(d + 2 * p), sq(rf[ea1]), rf[ea1], e_sq2);
                end
            end
            if (exp_w2) begin
                checks++;
                if ({wr_addr_2_o, wr_data_2_o} !== {AW'(d + 2 * p + 1), sq(rf[ea2])}) begin
                    errors++;
                    $display("FAIL lane2 write len=%0d pair=%0d: got a=%0d d=%h want a=%0d d=%h", l, p,
                             wr_addr_2_o, wr_data_2_o, AW'(d + 2 * p + 1), sq(rf[ea2]));
                end
            end
`ifdef SQUARE_SEQ_ABORT_EN
            checks++;
            if (aborted_o !== 1'b0) begin
                errors++;
                $display("FAIL aborted on normal run len=%0d cycle=%0d: got %b want 0", l, c, aborted_o);
            end
`endif
            scramble_inputs();
            start_i = (c == poke_c);
            @(negedge clk_i);
        end
        start_i = 1'b0;
        checks++;
        if ({busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o} !== 5'b0) begin
            errors++;
            $display("FAIL idle after done len=%0d: got busy,done,rd,w1,w2=%b want 00000", l,
                     {busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o});
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got or-reduce %b want 0", any_out);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if ({busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o} !== 5'b0) begin
                errors++;
                $display("FAIL quiet after reset cycle=%0d: got %b want 00000", c,
                         {busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o});
            end
        end
        // Reset mid-run, between edges.
        start_i = 1'b1; len_i = 7'd8; src_base_i = 6'd1; dst_base_i = 6'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL async reset mid-run: got or-reduce %b want 0", any_out);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if ({busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o} !== 5'b0) begin
                errors++;
                $display("FAIL strobe after mid-run reset cycle=%0d: got %b want 00000", c,
                         {busy_o, done_o, rd_en_o, wr_en_1_o, wr_en_2_o});
            end
        end
    endtask

    task automatic test_two_element();
        rf[4] = 24'h801401;
        rf[5] = 24'h801403;
        run_check(2, 4, 10, 0);
    endtask

    task automatic test_odd_wrap();
        run_check(3, 62, 63, 0);
    endtask

    task automatic test_zero_len();
        run_check(0, 17, 33, 0);
    endtask

    task automatic test_start_while_busy();
        run_check(4, 3, 20, 2);
        run_check(3, 40, 50, 7);
        run_check(5, 9, 0, 0);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 8; i++)
            run_check($urandom_range(0, 2**AW), $urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom_range(0, 12));
        run_check(2**AW, $urandom_range(0, 63), $urandom_range(0, 63), 0);
    endtask

`ifdef SQUARE_SEQ_ABORT_EN
    task automatic test_abort();
        int ab_c [2] = '{5, 3};
        for (int t = 0; t < 2; t++) begin
            int dc;
            logic exp_rd, exp_w;
            dc = ab_c[t] + 1;
            start_i = 1'b1; len_i = 7'd6; src_base_i = AW'($urandom); dst_base_i = AW'($urandom);
            @(posedge clk_i);
            @(negedge clk_i);
            start_i = 1'b0;
            for (int c = 1; c <= dc; c++) begin
                exp_rd = (c < dc) && ((c - 1) % 3 == 0);
                exp_w  = (c < dc) && ((c - 1) % 3 == 2);
                checks++;
                if ({done_o, aborted_o, rd_en_o, wr_en_1_o, wr_en_2_o} !== {c == dc, c == dc, exp_rd, exp_w, exp_w}) begin
                    errors++;
                    $display("FAIL abort at cycle %0d, cycle=%0d: got done,aborted,rd,w1,w2=%b want %b", ab_c[t], c,
                             {done_o, aborted_o, rd_en_o, wr_en_1_o, wr_en_2_o}, {c == dc, c == dc, exp_rd, exp_w, exp_w});
                end
                abort_i = (c == ab_c[t]);
                @(negedge clk_i);
            end
            abort_i = 1'b0;
            checks++;
            if ({busy_o, aborted_o} !== 2'b00) begin
                errors++;
                $display("FAIL idle after abort: got busy,aborted=%b want 00", {busy_o, aborted_o});
            end
        end
        run_check(4, 8, 12, 0);
    endtask
`endif

    initial begin
        start_i = 1'b0; len_i = '0; src_base_i = '0; dst_base_i = '0;
`ifdef SQUARE_SEQ_ABORT_EN
        abort_i = 1'b0;
`endif
        for (int i = 0; i < 2**AW; i++) rf[i] = W'($urandom);
        test_reset();
        test_two_element();
        test_odd_wrap();
        test_zero_len();
        test_start_while_busy();
        test_random_runs();
`ifdef SQUARE_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_seq.md
# square_seq

Sequencer for the two-lane `Square` unit in the vector machine. A single `start` command runs the block over a vector of `len` elements. It reads element pairs from a dual-read vector register file and drives them into the Square unit's `data_1`/`data_2` lanes. It writes both lane results back to a destination vector and signals completion. The Square unit itself stays combinational and sits outside this block.

## Interface
- `WIDTH`, default 24: element width; matches the Square unit parameter.
- `AW`, default 6: register-file address width.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: command strobe; sampled only in IDLE.
- `len`  in  AW+1: element count, 0..2^AW.
- `src_base`, `dst_base`  in  AW: source and destination base addresses.
- `busy`  out  1: high from the cycle after start acceptance until the done cycle, inclusive.
- `done`  out  1: one-cycle completion pulse.
- `rd_en`  out  1: register-file read strobe.
- `rd_addr_1`, `rd_addr_2`  out  AW: read addresses.
- `rd_data_1`, `rd_data_2`  in  WIDTH: read data, valid the cycle after `rd_en`.
- `sq_data_1`, `sq_data_2`  out  WIDTH: registered Square lane inputs.
- `sq_res_1`, `sq_res_2`  in  WIDTH: Square lane outputs.
- `wr_en_1`, `wr_en_2`  out  1: write strobes.
- `wr_addr_1`, `wr_addr_2`  out  AW: write addresses.
- `wr_data_1`, `wr_data_2`  out  WIDTH: write data.

## Operation
- FSM states: IDLE, READ, FEED, WRITE, DONE.
- **IDLE**
  - If `start`=1: capture `len`, `src_base` and `dst_base`; clear the pair index `k`.
  - If `len`=0, go to DONE; otherwise go to READ.
- **READ**
  - Drive `rd_en`=1, `rd_addr_1`=`src_base`+2k, `rd_addr_2`=`src_base`+2k+1.
  - Go to FEED.
- **FEED**
  - Register `rd_data_1` into `sq_data_1`.
  - Register `rd_data_2` into `sq_data_2`; if lane 2 is past the end of the vector (odd-length tail), load 0 instead.
  - Go to WRITE.
- **WRITE**
  - `wr_en_1`=1, `wr_data_1`=`sq_res_1`, `wr_addr_1`=`dst_base`+2k.
  - `wr_en_2`=1 only if 2k+1 < `len`; `wr_data_2`=`sq_res_2`, `wr_addr_2`=`dst_base`+2k+1.
  - If 2k+2 ≥ `len`, go to DONE; otherwise increment `k` and go to READ.
- **DONE**
  - `done`=1 for one cycle; go to IDLE.
- Address arithmetic is modulo 2^AW, so addresses wrap past the top of the register file silently.
- `start` is ignored in every state except IDLE.
- Captured `len`, `src_base` and `dst_base` are unaffected by input changes mid-run.
- Outputs are left unmodified by this block: `wr_data_*` is `sq_res_*` passed through.

## Timing
- Reset values: all outputs are 0 and the state is IDLE.
- Reset is asynchronous. When asserted mid-run, no further `rd_en` or `wr_en` pulses occur, and no `done` pulse occurs.
- Each element pair takes 3 cycles: READ, FEED, WRITE.
- Start accepted at edge T: READ occupies cycle T+1, and `done` is high in cycle T+1+3·ceil(len/2).
- For `len`=0, `done` is high in cycle T+1.
- `rd_data_*` is sampled one cycle after `rd_en`.
- `sq_data_*` is stable for the whole WRITE cycle.
- `rd_en`, `wr_en_*` and `done` are high for at most one cycle each.
- `rd_en` and `wr_en_*` are never high in the same cycle.
- `start` may be asserted in the cycle `done` is high. It is ignored there, and the earliest new acceptance is the following IDLE cycle.

## Configuration
- Macro: `SQUARE_SEQ_ABORT_EN`.
- **Defined:** adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort` in READ or FEED: go to DONE with no further writes.
  - `abort` in WRITE: complete the current pair's writes, then go to DONE.
  - `aborted` equals 1 in the DONE cycle of an aborted run, and 0 otherwise.
  - `abort` is ignored in IDLE and DONE.
- **Undefined:** neither port exists; runs always finish.

## Test plan
- **Reset:** assert `rst` asynchronously between edges → all outputs read 0 immediately. Release, hold `start`=0 for 5 cycles → no strobes.
- **Two-element run:** `len`=2, `src_base`=4, `dst_base`=10, register file holds 24'h801401 and 24'h801403 → reads at 4/5. `sq_data_1`=24'h801401, `sq_data_2`=24'h801403. One write pair to 10/11 equal to the Square model outputs. `done` at T+4.
- **Odd length with wrap:** `len`=3, `src_base`=62, `dst_base`=63, AW=6.
  - Reads at 62/63, then 0/1.
  - Writes at 63/0, then 1 only, with `wr_en_2`=0 on the second pair and `sq_data_2`=0.
  - `done` at T+7.
- **Zero length:** `len`=0 → no `rd_en`, no `wr_en`, `done` at T+1.
- **Start while busy:** pulse `start` during run 1 with a different `len` → ignored; run 1 timing unchanged. A `start` in the cycle after `done` is accepted.
- **Abort (with `SQUARE_SEQ_ABORT_EN` defined):** `len`=6, `abort` in the second pair's FEED cycle → only the first pair is written; `done` and `aborted` are high in the following cycle.
